// File: rtl/hazard_bubble_unit.sv
// Load-use hazard detector and bubble inserter between ID and the ID/EX register.
// Tracks in-flight loads for LOAD_LAT cycles and stalls PC/IF-ID on a dependent read.
module hazard_bubble_unit #(
   parameter int CTRL_W   = 16,
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1,
   parameter int STAT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_d,
   input  logic [CTRL_W-1:0] ctrl_d,
   input  logic [REG_AW-1:0] rs_d,
   input  logic [REG_AW-1:0] rt_d,
   input  logic              uses_rs_d,
   input  logic              uses_rt_d,
   input  logic              is_load_d,
   input  logic [REG_AW-1:0] rw_d,
   input  logic              flush,
   input  logic              hold,
   output logic [CTRL_W-1:0] ctrl_e,
   output logic [REG_AW-1:0] rw_e,
   output logic              is_load_e,
   output logic              stall_f,
   output logic              bubble,
   output logic [STAT_W-1:0] bubble_cnt
);

   // Entry 0 doubles as the ID/EX destination/load flags; older entries are loads further down.
   logic [LOAD_LAT-1:0] pend_v;
   logic [REG_AW-1:0]   pend_rw [LOAD_LAT];
   logic [CTRL_W-1:0]   ctrl_q;
   logic                haz;
   logic                kill;

   always_comb begin
      haz = 1'b0;
      for (int unsigned i = 0; i < LOAD_LAT; i++) begin
         // Register 0 is hard-wired, so a load targeting it never blocks anyone.
         if (pend_v[i] && (pend_rw[i] != '0) &&
             ((uses_rs_d && (rs_d == pend_rw[i])) || (uses_rt_d && (rt_d == pend_rw[i]))))
            haz = 1'b1;
      end
      haz = haz & valid_d;
   end

   assign kill    = flush | haz | ~valid_d;
   assign stall_f = reset & (hold | (haz & ~flush));
   assign bubble  = reset & haz & ~flush & ~hold;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_q     <= '0;
         pend_v     <= '0;
         bubble_cnt <= '0;
         for (int unsigned i = 0; i < LOAD_LAT; i++)
            pend_rw[i] <= '0;
      end else if (!hold) begin
         for (int unsigned i = 1; i < LOAD_LAT; i++) begin
            pend_v[i]  <= pend_v[i-1];
            pend_rw[i] <= pend_rw[i-1];
         end
         if (kill) begin
            ctrl_q     <= '0;
            pend_v[0]  <= 1'b0;
            pend_rw[0] <= '0;
         end else begin
            ctrl_q     <= ctrl_d;
            pend_v[0]  <= is_load_d;
            pend_rw[0] <= rw_d;
         end
         if (bubble && (bubble_cnt != '1))
            bubble_cnt <= bubble_cnt + 1'b1;
      end
   end

   assign ctrl_e    = ctrl_q;
   assign rw_e      = pend_rw[0];
   assign is_load_e = pend_v[0];

endmodule

// File: tb/tb_hazard_bubble_unit.sv
// Bench for hazard_bubble_unit: three parameterisations share one stimulus stream and are
// checked each cycle against a load-age model, plus directed literal expectations.
module tb_hazard_bubble_unit;

   localparam int NDUT = 3;
   localparam int LLS [NDUT] = '{1, 3, 2};
   localparam int SWS [NDUT] = '{16, 16, 4};

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        valid_d = 1'b0;
   logic [15:0] ctrl_d = '0;
   logic [4:0]  rs_d = '0, rt_d = '0, rw_d = '0;
   logic        uses_rs_d = 1'b0, uses_rt_d = 1'b0, is_load_d = 1'b0;
   logic        flush = 1'b0, hold = 1'b0;

   logic [15:0] ctrl_v [NDUT];
   logic [4:0]  rw_v [NDUT];
   logic [NDUT-1:0] ld_v, stall_v, bub_v;
   logic [15:0] cnt0, cnt1;
   logic [3:0]  cnt2;
   int unsigned cnt_v [NDUT];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_bubble_unit #(.CTRL_W(16), .REG_AW(5), .LOAD_LAT(1), .STAT_W(16)) u0 (
      .clk(clk), .reset(reset), .valid_d(valid_d), .ctrl_d(ctrl_d), .rs_d(rs_d), .rt_d(rt_d),
      .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d), .is_load_d(is_load_d), .rw_d(rw_d),
      .flush(flush), .hold(hold), .ctrl_e(ctrl_v[0]), .rw_e(rw_v[0]), .is_load_e(ld_v[0]),
      .stall_f(stall_v[0]), .bubble(bub_v[0]), .bubble_cnt(cnt0));

   hazard_bubble_unit #(.CTRL_W(16), .REG_AW(5), .LOAD_LAT(3), .STAT_W(16)) u1 (
      .clk(clk), .reset(reset), .valid_d(valid_d), .ctrl_d(ctrl_d), .rs_d(rs_d), .rt_d(rt_d),
      .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d), .is_load_d(is_load_d), .rw_d(rw_d),
      .flush(flush), .hold(hold), .ctrl_e(ctrl_v[1]), .rw_e(rw_v[1]), .is_load_e(ld_v[1]),
      .stall_f(stall_v[1]), .bubble(bub_v[1]), .bubble_cnt(cnt1));

   hazard_bubble_unit #(.CTRL_W(16), .REG_AW(5), .LOAD_LAT(2), .STAT_W(4)) u2 (
      .clk(clk), .reset(reset), .valid_d(valid_d), .ctrl_d(ctrl_d), .rs_d(rs_d), .rt_d(rt_d),
      .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d), .is_load_d(is_load_d), .rw_d(rw_d),
      .flush(flush), .hold(hold), .ctrl_e(ctrl_v[2]), .rw_e(rw_v[2]), .is_load_e(ld_v[2]),
      .stall_f(stall_v[2]), .bubble(bub_v[2]), .bubble_cnt(cnt2));

   assign cnt_v[0] = 32'(cnt0);
   assign cnt_v[1] = 32'(cnt1);
   assign cnt_v[2] = 32'(cnt2);

   // Model: per register, the advance-cycle at which its latest load entered EX.
   int unsigned adv [NDUT];
   bit          lv [NDUT][32];
   int unsigned lt [NDUT][32];
   bit [15:0]   m_ctrl [NDUT];
   bit [4:0]    m_rw [NDUT];
   bit          m_ld [NDUT];
   int unsigned m_cnt [NDUT];

   function automatic bit pending(int k, bit [4:0] r);
      return (r != 0) && lv[k][r] && ((adv[k] - lt[k][r]) < LLS[k]);
   endfunction

   function automatic bit mhaz(int k);
      return valid_d && ((uses_rs_d && pending(k, rs_d)) || (uses_rt_d && pending(k, rt_d)));
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < NDUT; k++) begin
            for (int r = 0; r < 32; r++) lv[k][r] = 1'b0;
            m_ctrl[k] = '0; m_rw[k] = '0; m_ld[k] = 1'b0; m_cnt[k] = 0;
         end
      end else if (!hold) begin
         for (int k = 0; k < NDUT; k++) begin
            bit h;
            h = mhaz(k);
            adv[k] = adv[k] + 1;
            if (flush || h || !valid_d) begin
               m_ctrl[k] = '0; m_rw[k] = '0; m_ld[k] = 1'b0;
            end else begin
               m_ctrl[k] = ctrl_d; m_rw[k] = rw_d; m_ld[k] = is_load_d;
               if (is_load_d) begin
                  lv[k][rw_d] = 1'b1;
                  lt[k][rw_d] = adv[k];
               end
            end
            if (h && !flush && (m_cnt[k] < ((1 << SWS[k]) - 1)))
               m_cnt[k] = m_cnt[k] + 1;
         end
      end
   end

   task automatic chk(input string name, input int k, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s dut%0d at %0t: got %0h expected %0h", name, k, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < NDUT; k++) begin
         bit h;
         h = mhaz(k);
         chk("stall_f", k, stall_v[k], reset && (hold || (h && !flush)));
         chk("bubble", k, bub_v[k], reset && h && !flush && !hold);
         chk("ctrl_e", k, ctrl_v[k], m_ctrl[k]);
         chk("rw_e", k, rw_v[k], m_rw[k]);
         chk("is_load_e", k, ld_v[k], m_ld[k]);
         chk("bubble_cnt", k, cnt_v[k], m_cnt[k]);
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic set_id(input bit v, input bit [15:0] c, input bit [4:0] rs, input bit [4:0] rt,
                         input bit urs, input bit urt, input bit ld, input bit [4:0] rw);
      valid_d = v; ctrl_d = c; rs_d = rs; rt_d = rt;
      uses_rs_d = urs; uses_rt_d = urt; is_load_d = ld; rw_d = rw;
   endtask

   task automatic idle(input int n);
      set_id(0, '0, '0, '0, 0, 0, 0, '0);
      repeat (n) step();
   endtask

   // Present an instruction in ID and hold it there until dut k lets it issue.
   task automatic issue(input int k, input bit [15:0] c, input bit [4:0] rs, input bit [4:0] rt,
                        input bit urs, input bit urt, input bit ld, input bit [4:0] rw,
                        output int nb);
      set_id(1, c, rs, rt, urs, urt, ld, rw);
      nb = 0;
      for (int i = 0; i < 30; i++) begin
         #2;
         if (!stall_v[k]) break;
         nb++;
         @(posedge clk); #1;
      end
      if (nb >= 30) chk("issue_timeout", k, nb, 0);
      step();
   endtask

   localparam bit [15:0] LW_C  = 16'h00A1;
   localparam bit [15:0] ADD_C = 16'h1234;
   localparam bit [15:0] IND_C = 16'h0C0F;

   initial begin
      int nb;
      longint c0, c1;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < NDUT; k++) begin
         chk("rst_ctrl", k, ctrl_v[k], 0);
         chk("rst_cnt", k, cnt_v[k], 0);
         chk("rst_stall", k, stall_v[k], 0);
      end
      reset = 1'b1;
      idle(1);

      // LOAD_LAT=1: LW $8 ; ADD $9,$8,$1
      issue(0, LW_C, 5'd29, 5'd8, 1, 0, 1, 5'd8, nb);
      chk("t1_lw_nb", 0, nb, 0);
      set_id(1, ADD_C, 5'd8, 5'd1, 1, 1, 0, 5'd9);
      #2;
      chk("t1_stall", 0, stall_v[0], 1);
      chk("t1_bubble", 0, bub_v[0], 1);
      @(posedge clk); #3;
      chk("t1_ctrl_bubble", 0, ctrl_v[0], 0);
      chk("t1_stall_clear", 0, stall_v[0], 0);
      @(posedge clk); #1;
      chk("t1_ctrl_add", 0, ctrl_v[0], ADD_C);
      chk("t1_cnt", 0, cnt_v[0], 1);
      idle(4);

      // LOAD_LAT=3: dependent directly behind load
      issue(1, LW_C, 5'd29, 5'd8, 1, 0, 1, 5'd8, nb);
      issue(1, ADD_C, 5'd8, 5'd1, 1, 1, 0, 5'd9, nb);
      chk("t2_nb", 1, nb, 3);
      chk("t2_ctrl", 1, ctrl_v[1], ADD_C);
      idle(4);

      // distance 2
      issue(1, LW_C, 5'd29, 5'd8, 1, 0, 1, 5'd8, nb);
      issue(1, IND_C, 5'd2, 5'd3, 1, 1, 0, 5'd4, nb);
      chk("t3_ind_nb", 1, nb, 0);
      issue(1, ADD_C, 5'd8, 5'd1, 1, 1, 0, 5'd9, nb);
      chk("t3_nb", 1, nb, 2);
      idle(4);

      // load to $0
      issue(1, LW_C, 5'd29, 5'd0, 1, 0, 1, 5'd0, nb);
      issue(1, ADD_C, 5'd0, 5'd0, 1, 1, 0, 5'd9, nb);
      chk("t4_r0_nb", 1, nb, 0);
      idle(4);

      // rt matches but not read
      issue(1, LW_C, 5'd29, 5'd8, 1, 0, 1, 5'd8, nb);
      issue(1, ADD_C, 5'd1, 5'd8, 1, 0, 0, 5'd9, nb);
      chk("t5_unused_rt_nb", 1, nb, 0);
      idle(4);

      // both sources match: single stall sequence
      c1 = cnt_v[1];
      issue(1, LW_C, 5'd29, 5'd10, 1, 0, 1, 5'd10, nb);
      issue(1, ADD_C, 5'd10, 5'd10, 1, 1, 0, 5'd9, nb);
      chk("t6_both_nb", 1, nb, 3);
      chk("t6_cnt_delta", 1, cnt_v[1] - c1, 3);
      idle(4);

      // hazard together with flush
      issue(0, LW_C, 5'd29, 5'd8, 1, 0, 1, 5'd8, nb);
      c0 = cnt_v[0];
      set_id(1, ADD_C, 5'd8, 5'd1, 1, 1, 0, 5'd9);
      flush = 1'b1;
      #2;
      chk("t7_stall", 0, stall_v[0], 0);
      chk("t7_bubble", 0, bub_v[0], 0);
      step();
      chk("t7_ctrl", 0, ctrl_v[0], 0);
      chk("t7_cnt", 0, cnt_v[0], c0);
      flush = 1'b0;
      idle(4);

      // hold for two cycles in the middle of a 3-bubble stall
      issue(1, LW_C, 5'd29, 5'd8, 1, 0, 1, 5'd8, nb);
      set_id(1, ADD_C, 5'd8, 5'd1, 1, 1, 0, 5'd9);
      step();
      c1 = cnt_v[1];
      hold = 1'b1;
      #2;
      chk("t8_hold_stall", 1, stall_v[1], 1);
      chk("t8_hold_bubble", 1, bub_v[1], 0);
      step();
      step();
      chk("t8_hold_ctrl", 1, ctrl_v[1], 0);
      chk("t8_hold_cnt", 1, cnt_v[1], c1);
      hold = 1'b0;
      issue(1, ADD_C, 5'd8, 5'd1, 1, 1, 0, 5'd9, nb);
      chk("t8_rest_nb", 1, nb, 2);
      chk("t8_ctrl", 1, ctrl_v[1], ADD_C);
      chk("t8_cnt", 1, cnt_v[1], c1 + 2);
      idle(4);

      // saturation on the 4-bit counter
      for (int i = 0; i < 20; i++) begin
         issue(2, LW_C, 5'd29, 5'd8, 1, 0, 1, 5'd8, nb);
         issue(2, ADD_C, 5'd8, 5'd1, 1, 1, 0, 5'd9, nb);
         chk("t9_nb", 2, nb, 2);
      end
      chk("t9_sat", 2, cnt_v[2], 15);
      idle(3);
      chk("t9_sat_hold", 2, cnt_v[2], 15);

      // reset during the second of three bubbles
      issue(1, LW_C, 5'd29, 5'd8, 1, 0, 1, 5'd8, nb);
      set_id(1, ADD_C, 5'd8, 5'd1, 1, 1, 0, 5'd9);
      step();
      #2;
      chk("t10_stall_pre", 1, stall_v[1], 1);
      reset = 1'b0;
      #1;
      for (int k = 0; k < NDUT; k++) begin
         chk("t10_stall", k, stall_v[k], 0);
         chk("t10_bubble", k, bub_v[k], 0);
         chk("t10_ctrl", k, ctrl_v[k], 0);
         chk("t10_ld", k, ld_v[k], 0);
         chk("t10_cnt", k, cnt_v[k], 0);
      end
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      chk("t10_post_stall", 1, stall_v[1], 0);
      @(posedge clk); #1;
      chk("t10_post_ctrl", 1, ctrl_v[1], ADD_C);
      chk("t10_post_cnt", 1, cnt_v[1], 0);
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/hazard_bubble_unit.md
Name: hazard_bubble_unit

Overview:
- Parametrised load-use hazard detector and bubble inserter sitting between the ID stage and the ID/EX pipeline register of the MIPS pipeline.
- Tracks in-flight loads in a LOAD_LAT-deep scoreboard and stalls PC and IF/ID while any pending load's destination matches a source operand of the ID instruction.
- While stalling, loads an all-zero control bundle (bubble) into its own ID/EX control register.
- Adds branch flush, downstream hold, and a saturating bubble statistics counter.

Parameters:
- CTRL_W, 16, width of the packed ID control bundle (RegWrite, MemtoReg, MemWrite, ALUSrc, ALUControl, isShift, isJal, Stop, ...).
- REG_AW, 5, register-address width.
- LOAD_LAT, 1, bubbles a dependent instruction needs behind a load (legal 1..4).
- STAT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_d  in  1  ID holds a real instruction.
- ctrl_d  in  CTRL_W  decoded control bundle of the ID instruction.
- rs_d  in  REG_AW  source register 1.
- rt_d  in  REG_AW  source register 2.
- uses_rs_d  in  1  instruction reads rs.
- uses_rt_d  in  1  instruction reads rt.
- is_load_d  in  1  ID instruction is LW.
- rw_d  in  REG_AW  destination register of the ID instruction.
- flush  in  1  taken branch/jump resolved; ID instruction is wrong-path.
- hold  in  1  downstream (memory) stall; freeze this unit.
- ctrl_e  out  CTRL_W  registered ID/EX control bundle.
- rw_e  out  REG_AW  registered ID/EX destination register.
- is_load_e  out  1  registered: EX holds a load.
- stall_f  out  1  combinational: freeze PC and IF/ID.
- bubble  out  1  combinational: a hazard bubble is being inserted this cycle.
- bubble_cnt  out  STAT_W  saturating count of hazard bubbles.

Behaviour:
- Reset (reset=0, asynchronous): ctrl_e=0, rw_e=0, is_load_e=0, all scoreboard entries invalid, bubble_cnt=0.
  - stall_f and bubble are 0 while reset is asserted.
- Scoreboard: pend_v[0..LOAD_LAT-1] and pend_rw[0..LOAD_LAT-1].
  - Entry 0 describes the instruction currently in ID/EX (pend_v[0] = is_load_e).
  - Entry i is the load that entered EX i cycles ago.
  - On each non-hold edge: entry i+1 <= entry i; entry 0 <= {is_load written into ID/EX, rw written}. The oldest entry drops off.
- Hazard (combinational):
  - haz = valid_d & any i: pend_v[i] & pend_rw[i]!=0 & ((uses_rs_d & rs_d==pend_rw[i]) | (uses_rt_d & rt_d==pend_rw[i])).
  - Register 0 never causes a hazard.
- stall_f = hold | (haz & ~flush).
- bubble = haz & ~flush & ~hold.
- ID/EX register update on the rising edge:
  - hold=1: ctrl_e, rw_e, is_load_e and the scoreboard all retain their values.
  - else if flush | haz | ~valid_d: ctrl_e <= 0, rw_e <= 0, is_load_e <= 0 (bubble).
  - else: ctrl_e <= ctrl_d, rw_e <= rw_d, is_load_e <= is_load_d.
- Stall length:
  - A dependent instruction directly behind a load sees exactly LOAD_LAT bubble cycles, then issues.
  - Dependency at distance d (d-1 independent instructions between) sees max(0, LOAD_LAT-d+1) bubbles.
- Simultaneous events:
  - flush beats haz: no stall, a bubble is still loaded, bubble output is 0, no count.
  - hold beats everything.
- bubble_cnt:
  - Increments on each edge where bubble=1.
  - Saturates at 2^STAT_W-1 and does not wrap.
- Reset asserted mid-stall: every output clears immediately, no stall persists after release, and the first post-reset instruction issues without a bubble.
- Latency: ID to ctrl_e is 1 cycle when no hazard.

Test Plan:
- LOAD_LAT=1: issue LW $8 followed by ADD $9,$8,$1 -> one cycle with stall_f=1, bubble=1, ctrl_e=0; ADD's ctrl appears on the next edge; bubble_cnt=1.
- LOAD_LAT=3, same pair -> exactly 3 consecutive bubble cycles. LW, independent instruction, then dependent -> 2 bubbles. LW $0 followed by a use of $0 -> no stall.
- Apply hazard and flush in the same cycle -> stall_f=0, bubble=0, ctrl_e=0 after the edge, bubble_cnt unchanged. Apply hold=1 for 2 cycles mid-stall -> ctrl_e, scoreboard and count frozen, then the remaining bubbles complete.
- Dependency only via rt with uses_rt_d=0 -> no stall. Dependency via both rs and rt -> a single stall sequence, not a double one.
- STAT_W=4, force 20 hazards -> bubble_cnt reads 15 and stays there.
- Assert reset (reset=0) during the 2nd of 3 bubbles -> all outputs 0 asynchronously. After release, a dependent instruction in ID with no pending load issues without stall.
